// File: rtl/conv_phase_timer_if.sv
// Bus between the conv sequencer side and the phase timer.
// master drives the phase and handshake inputs; slave is the timer itself.
interface conv_phase_timer_if #(
    parameter int CNT_W = 10
);
    logic [2:0]       current_state;
    logic             start;
    logic             in_valid;
    logic             out_ready;
    logic             state_end;
    logic             out_valid;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;

    modport master (
        output current_state, start, in_valid, out_ready,
        input  state_end, out_valid, cnt, row, col
    );

    modport slave (
        input  current_state, start, in_valid, out_ready,
        output state_end, out_valid, cnt, row, col
    );
endinterface

// File: rtl/conv_phase_timer.sv
// Phase timer for the conv sequencer: counts A/B/C work; state_end is registered and rises one edge after the last item.
// Backpressure: in_valid gates B pixel counting, out_ready stalls C beats; nothing is counted while state_end is high.
module conv_phase_timer #(
    parameter int W_LEN   = 9,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int OUT_LEN = 16,
    parameter int CNT_W   = 10
) (
    input  logic                clk,
    input  logic                rstn,
    conv_phase_timer_if.slave   bus
);
    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_A    = 3'd1;
    localparam logic [2:0] ST_B    = 3'd2;
    localparam logic [2:0] ST_C    = 3'd3;

    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(W_LEN - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             state_end_q, state_end_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [2:0]       prev_state_q, prev_state_d;

    logic illegal;
    logic phase_chg;
    logic cnt_idle;
    logic out_valid;
    logic beat;

    assign illegal   = bus.current_state[2];
    assign phase_chg = (bus.current_state != prev_state_q);
    assign cnt_idle  = (cnt_q == '0) && (row_q == '0) && (col_q == '0);
    assign out_valid = (bus.current_state == ST_C) && !state_end_q;
    assign beat      = out_valid && bus.out_ready;

    always_comb begin
        state_end_d  = 1'b0;
        cnt_d        = cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        prev_state_d = bus.current_state;

        if (illegal) begin
            cnt_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (state_end_q) begin
            // lockout: the sequencer advances on this edge, hold everything
        end else if (phase_chg && !cnt_idle) begin
            // sequencer jumped phases with work in flight: resync to zero
            cnt_d = '0;
            row_d = '0;
            col_d = '0;
        end else begin
            unique case (bus.current_state)
                ST_INIT: state_end_d = bus.start;
                ST_A: begin
                    if (cnt_q == W_LAST) begin
                        cnt_d       = '0;
                        state_end_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                ST_B: begin
                    if (bus.in_valid) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d       = '0;
                                state_end_d = 1'b1;
                            end else begin
                                row_d = row_q + ONE;
                            end
                        end else begin
                            col_d = col_q + ONE;
                        end
                    end
                end
                ST_C: begin
                    if (beat) begin
                        if (cnt_q == OUT_LAST) begin
                            cnt_d       = '0;
                            state_end_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_end_q  <= 1'b0;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            prev_state_q <= ST_INIT;
        end else begin
            state_end_q  <= state_end_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            prev_state_q <= prev_state_d;
        end
    end

    assign bus.state_end = state_end_q && !illegal;
    assign bus.out_valid = out_valid;
    assign bus.cnt = ((bus.current_state == ST_A) || (bus.current_state == ST_C)) ? cnt_q : '0;
    assign bus.row = (bus.current_state == ST_B) ? row_q : '0;
    assign bus.col = (bus.current_state == ST_B) ? col_q : '0;
endmodule

// File: tb/tb_conv_phase_timer.sv
// Bench for conv_phase_timer: a behavioural item-count model plus a bench-side sequencer,
// random handshake stimulus and a few literal checks on the phase boundaries.
module tb_conv_phase_timer;
    localparam int W_LEN   = 9;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int OUT_LEN = 2;
    localparam int CNT_W   = 10;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv_phase_timer_if #(.CNT_W(CNT_W)) bus ();

    conv_phase_timer #(
        .W_LEN(W_LEN), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_LEN(OUT_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Model: sequencer phase, items finished in this phase, and the pending end pulse.
    int m_seq;
    int m_k;
    bit m_end;
    int m_pulses;
    int n_vec;
    int n_err;
    int pulses;
    bit prev_end;
    bit chk_en;

    function automatic void chk(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic int phase_len(int s);
        case (s)
            1:       return W_LEN;
            2:       return IMG_W * IMG_H;
            default: return OUT_LEN;
        endcase
    endfunction

    task automatic model_reset();
        m_seq = 0;
        m_k   = 0;
        m_end = 1'b0;
    endtask

    task automatic model_step();
        bit adv;
        if (!rstn) begin
            model_reset();
        end else if (m_seq >= 4) begin
            model_reset();
        end else if (m_end) begin
            m_end = 1'b0;
            m_seq = (m_seq == 3) ? 1 : m_seq + 1;
        end else begin
            adv = 1'b0;
            case (m_seq)
                0: if (bus.start) begin m_end = 1'b1; m_pulses++; end
                1: adv = 1'b1;
                2: adv = bus.in_valid;
                3: adv = bus.out_ready;
                default: ;
            endcase
            if (adv) begin
                m_k++;
                if (m_k == phase_len(m_seq)) begin
                    m_k   = 0;
                    m_end = 1'b1;
                    m_pulses++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.current_state = 3'(m_seq);
        @(negedge clk);
    endtask

    task automatic rand_hs(int pct);
        bus.in_valid  = ($urandom_range(0, 99) < pct);
        bus.out_ready = ($urandom_range(0, 99) < pct);
    endtask

    always @(negedge clk) begin
        int ec, er, ecl, ee, ev;
        if (chk_en) begin
            ee  = (m_seq < 4) ? int'(m_end) : 0;
            ec  = (m_seq == 1 || m_seq == 3) ? m_k : 0;
            er  = (m_seq == 2) ? m_k / IMG_W : 0;
            ecl = (m_seq == 2) ? m_k % IMG_W : 0;
            ev  = (m_seq == 3 && !m_end) ? 1 : 0;
            chk("state_end", int'(bus.state_end), ee);
            chk("cnt", int'(bus.cnt), ec);
            chk("row", int'(bus.row), er);
            chk("col", int'(bus.col), ecl);
            chk("out_valid", int'(bus.out_valid), ev);
            chk("no_adjacent_end", int'(bus.state_end && prev_end), 0);
            if (bus.state_end) pulses++;
            prev_end = bus.state_end;
        end
    end

    initial begin
        int last_r, last_c;
        bit done;
        n_vec = 0; n_err = 0; pulses = 0; m_pulses = 0; prev_end = 1'b0; chk_en = 1'b0;
        rstn = 1'b0;
        bus.current_state = 3'd0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        chk_en = 1'b1;
        tick();
        chk("rst_state_end", int'(bus.state_end), 0);
        chk("rst_cnt", int'(bus.cnt), 0);
        chk("rst_row", int'(bus.row), 0);
        chk("rst_col", int'(bus.col), 0);

        // INIT idle, then one start request
        rstn = 1'b1;
        repeat (10) begin
            rand_hs(50);
            tick();
            chk("init_idle", int'(bus.state_end), 0);
        end
        bus.start = 1'b1;
        tick();
        chk("start_pulse", int'(bus.state_end), 1);
        bus.start = 1'b0;

        // A: cnt 0..8 then end pulse on the 10th cycle with cnt back at 0
        for (int i = 1; i <= 10; i++) begin
            rand_hs(50);
            bus.start = $urandom_range(0, 1);
            tick();
            chk("a_cnt", int'(bus.cnt), (i <= W_LEN) ? i - 1 : 0);
            chk("a_end", int'(bus.state_end), (i == W_LEN + 1) ? 1 : 0);
        end

        // B: in_valid toggling, record last index before the end pulse
        last_r = -1; last_c = -1; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            bus.in_valid = (cyc % 2 == 0);
            tick();
            if (m_seq == 2 && bus.state_end) done = 1'b1;
            else if (m_seq == 2) begin
                last_r = int'(bus.row);
                last_c = int'(bus.col);
            end
        end
        chk("b_finished", int'(done), 1);
        chk("b_last_row", last_r, IMG_H - 1);
        chk("b_last_col", last_c, IMG_W - 1);

        // C: ready held low, then two accepted beats
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.out_ready = 1'b0;
            tick();
            chk("c_stall_cnt", int'(bus.cnt), 0);
            chk("c_stall_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("c_beat1_cnt", int'(bus.cnt), 1);
        tick();
        chk("c_end", int'(bus.state_end), 1);
        chk("c_lockout_valid", int'(bus.out_valid), 0);
        tick();
        chk("next_a_cnt", int'(bus.cnt), 0);
        chk("next_a_end", int'(bus.state_end), 0);

        // Reset in the middle of B at row 1, col 2
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            bus.in_valid = 1'b1;
            tick();
            if (m_seq == 2 && m_k == IMG_W + 2 && !m_end) done = 1'b1;
        end
        chk("midb_reached", int'(done), 1);
        chk("midb_row", int'(bus.row), 1);
        chk("midb_col", int'(bus.col), 2);
        #2;
        rstn = 1'b0;
        model_reset();
        bus.current_state = 3'd0;
        #1;
        chk("async_row", int'(bus.row), 0);
        chk("async_col", int'(bus.col), 0);
        chk("async_cnt", int'(bus.cnt), 0);
        chk("async_end", int'(bus.state_end), 0);
        repeat (2) tick();
        rstn = 1'b1;
        bus.start = 1'b0;
        repeat (5) begin
            rand_hs(50);
            tick();
            chk("post_rst_idle", int'(bus.state_end), 0);
        end

        // Illegal phase code injected mid-A
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            tick();
            if (m_seq == 1 && m_k == 4) done = 1'b1;
        end
        chk("illegal_setup", int'(done), 1);
        m_seq = 6; m_k = 0; m_end = 1'b0;
        bus.current_state = 3'd6;
        #1;
        chk("illegal_cnt", int'(bus.cnt), 0);
        chk("illegal_valid", int'(bus.out_valid), 0);
        chk("illegal_end", int'(bus.state_end), 0);
        tick();
        tick();
        chk("recover_init_end", int'(bus.state_end), 0);

        // Three tiles back to back with random handshakes
        pulses = 0;
        m_pulses = 0;
        bus.start = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            rand_hs(75);
            if (m_seq != 0) bus.start = $urandom_range(0, 1);
            tick();
            if (m_pulses == 1 + 3 * 3) done = 1'b1;
        end
        chk("loop_finished", int'(done), 1);
        tick();
        chk("loop_pulses", pulses, 1 + 3 * 3);
        chk("loop_back_in_a_cnt", int'(bus.cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
